regfile_sb: RTL

Parametrised register file with integrated scoreboard for the RISC CPU datapath; it is the next generation of the fixed 16-bit, two-address register file. It provides two registered read ports, one write port with write-through bypass, an optional hard-wired zero register, and per-register pending-write (busy) bits. Decode reads operands and reserves destinations through it, writeback writes through it, and the hazard unit uses its busy outputs to stall.

---
 rtl/regfile_sb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard: 2 registered read ports, 1 write port with optional bypass.
// Latency: 1 cycle from address to A_data/B_data/A_busy/B_busy; any_busy reflects next-state busy vector.
// Backpressure: none; the hazard unit stalls upstream on A_busy/B_busy/any_busy.
module regfile_sb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter bit          R0_ZERO = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  output logic [DATA_W-1:0] A_data,
  output logic [DATA_W-1:0] B_data,
  output logic              A_busy,
  output logic              B_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] DA,
  input  logic [DATA_W-1:0] D_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic              any_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              a_busy_q, a_busy_d;
  logic              b_busy_q, b_busy_d;
  logic              any_busy_q;

  logic              wr_allowed;
  logic              rsv_allowed;

  // Writes and reservations to r0 are dropped when r0 is hard-wired to zero.
  always_comb begin
    wr_allowed  = we;
    rsv_allowed = rsv_en;
    if (R0_ZERO && DA == '0) begin
      wr_allowed = 1'b0;
    end
    if (R0_ZERO && rsv_addr == '0) begin
      rsv_allowed = 1'b0;
    end
  end

  // Storage update: one write per cycle; reset clears every register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_allowed) begin
      regs_q[DA] <= D_data;
    end
  end

  // Read value for port A: zero register first, then bypass, then stored contents.
  always_comb begin
    a_data_d = regs_q[AA];
    if (BYPASS && we && DA == AA) begin
      a_data_d = D_data;
    end
    if (R0_ZERO && AA == '0) begin
      a_data_d = '0;
    end
  end

  // Read value for port B, formed the same way as port A.
  always_comb begin
    b_data_d = regs_q[BA];
    if (BYPASS && we && DA == BA) begin
      b_data_d = D_data;
    end
    if (R0_ZERO && BA == '0) begin
      b_data_d = '0;
    end
  end

  // Busy next state: completing write clears, new reservation sets (and wins), flush clears all.
  always_comb begin
    busy_d = busy_q;
    if (we) begin
      busy_d[DA] = 1'b0;
    end
    if (rsv_allowed) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    if (R0_ZERO) begin
      busy_d[0] = 1'b0;
    end
  end

  // Reader busy: a write completing this cycle hides the bit; same-cycle reservations are not seen.
  always_comb begin
    a_busy_d = busy_q[AA] & ~(we && DA == AA);
    b_busy_d = busy_q[BA] & ~(we && DA == BA);
    if (flush) begin
      a_busy_d = 1'b0;
      b_busy_d = 1'b0;
    end
  end

  // Busy vector and registered read-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      a_busy_q   <= 1'b0;
      b_busy_q   <= 1'b0;
      any_busy_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      a_busy_q   <= a_busy_d;
      b_busy_q   <= b_busy_d;
      any_busy_q <= |busy_d;
    end
  end

  assign A_data   = a_data_q;
  assign B_data   = b_data_q;
  assign A_busy   = a_busy_q;
  assign B_busy   = b_busy_q;
  assign any_busy = any_busy_q;

endmodule
